// File: rtl/serial_hsub_if.sv
// Start/done operand and result bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status and result.
interface serial_hsub_if #(
   parameter int WIDTH = 8
);
   // Handshake: start is taken only while the slave is idle. It has no valid/ready
   // pair. busy is high while bits are processed. done pulses for one cycle, and
   // diff/bout hold from that pulse until the next completion or reset.
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
      output start, a, b,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, bout
   );
endinterface

// File: rtl/serial_hsub.sv
// Bit-serial subtractor: diff = a - b mod 2^WIDTH, LSB first, one bit per clock,
// built from two cascaded half-subtractor cells with a registered borrow.
module serial_hsub #(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   serial_hsub_if.slave bus,
   output logic [1:0] o_dbg_state
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res;
   logic [CNT_W-1:0] r_cnt;
   logic             r_br;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;

   logic w_a0, w_b0;
   logic w_hs1_d, w_hs1_b;
   logic w_d, w_hs2_b;
   logic w_br_next;

   // First cell subtracts b from a; the second subtracts the incoming borrow.
   assign w_a0      = r_a_sh[0];
   assign w_b0      = r_b_sh[0];
   assign w_hs1_d   = w_a0 ^ w_b0;
   assign w_hs1_b   = ~w_a0 & w_b0;
   assign w_d       = w_hs1_d ^ r_br;
   assign w_hs2_b   = ~w_hs1_d & r_br;
   assign w_br_next = w_hs1_b | w_hs2_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_br    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_diff  <= '0;
         r_bout  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_a_sh  <= bus.a;
                  r_b_sh  <= bus.b;
                  r_br    <= 1'b0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_res  <= {w_d, r_res[WIDTH-1:1]};
               r_a_sh <= r_a_sh >> 1;
               r_b_sh <= r_b_sh >> 1;
               r_br   <= w_br_next;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == LAST_BIT) begin
                  // The last bit goes straight into diff rather than through r_res.
                  r_diff  <= {w_d, r_res[WIDTH-1:1]};
                  r_bout  <= w_br_next;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.diff    = r_diff;
   assign bus.bout    = r_bout;
   assign o_dbg_state = r_state;
endmodule

// File: tb/tb_serial_hsub.sv
// Bench for serial_hsub: directed vectors, random ops, held start, reset mid-run,
// and an exhaustive sweep on a 4-bit instance.
module tb_serial_hsub;
   logic clk;
   logic rst_n;
   logic [1:0] dbg8, dbg4;
   int n_checks = 0;
   int n_fail   = 0;

   serial_hsub_if #(.WIDTH(8)) bus8 ();
   serial_hsub_if #(.WIDTH(4)) bus4 ();

   serial_hsub #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8), .o_dbg_state(dbg8));
   serial_hsub #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4), .o_dbg_state(dbg4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       bo;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: a full-width unsigned subtraction whose bit WIDTH is the borrow.
   function automatic logic [8:0] ref_sub8(input logic [7:0] a, input logic [7:0] b);
      return {1'b0, a} - {1'b0, b};
   endfunction

   function automatic logic [4:0] ref_sub4(input logic [3:0] a, input logic [3:0] b);
      return {1'b0, a} - {1'b0, b};
   endfunction

   // Called at posedge+1 with the DUT idle; returns at posedge+1 back in idle.
   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] d, output logic bo, output int lat);
      bus8.start = 1'b1;
      bus8.a = a;
      bus8.b = b;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      bus8.a = 8'($urandom);
      bus8.b = 8'($urandom);
      lat = 0;
      while (bus8.done !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      d  = bus8.diff;
      bo = bus8.bout;
      chk("busy_low_with_done8", 32'(bus8.busy), 32'(0));
      @(posedge clk); #1;
      chk("done_single_cycle8", 32'(bus8.done), 32'(0));
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b,
                      output logic [3:0] d, output logic bo, output int lat);
      bus4.start = 1'b1;
      bus4.a = a;
      bus4.b = b;
      @(posedge clk); #1;
      bus4.start = 1'b0;
      lat = 0;
      while (bus4.done !== 1'b1 && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
      d  = bus4.diff;
      bo = bus4.bout;
      @(posedge clk); #1;
   endtask

   logic [7:0] d8;
   logic [3:0] d4;
   logic       bo;
   int         lat;
   logic [8:0] r8;
   logic [4:0] r4;
   logic [7:0] av[30];
   logic [7:0] bv[30];
   logic [7:0] last_d;
   logic       last_bo;

   initial begin
      vecs[0] = '{8'h35, 8'h12, 8'h23, 1'b0};
      vecs[1] = '{8'h12, 8'h35, 8'hDD, 1'b1};
      vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
      vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
      vecs[4] = '{8'hA5, 8'h00, 8'hA5, 1'b0};
      vecs[5] = '{8'h00, 8'hFF, 8'h01, 1'b1};
      vecs[6] = '{8'h80, 8'h7F, 8'h01, 1'b0};

      rst_n = 1'b0;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
      bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus8.busy), 32'(0));
      chk("rst_done", 32'(bus8.done), 32'(0));
      chk("rst_diff", 32'(bus8.diff), 32'(0));
      chk("rst_bout", 32'(bus8.bout), 32'(0));
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         op8(vecs[i].a, vecs[i].b, d8, bo, lat);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(8));
         chk($sformatf("vec%0d_diff", i), 32'(d8), 32'(vecs[i].d));
         chk($sformatf("vec%0d_bout", i), 32'(bo), 32'(vecs[i].bo));
      end

      for (int i = 0; i < 40; i++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         r8 = ref_sub8(ra, rb);
         op8(ra, rb, d8, bo, lat);
         chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(8));
         chk($sformatf("rnd%0d_diff", i), 32'(d8), 32'(r8[7:0]));
         chk($sformatf("rnd%0d_bout", i), 32'(bo), 32'(r8[8]));
      end
      last_d  = d8;
      last_bo = bo;

      // Start held high with operands changing every cycle: accepts at edges 0, 10, 20.
      for (int i = 0; i < 30; i++) begin
         av[i] = 8'($urandom);
         bv[i] = 8'($urandom);
         bus8.start = 1'b1;
         bus8.a = av[i];
         bus8.b = bv[i];
         @(posedge clk); #1;
         chk($sformatf("hold%0d_done", i), 32'(bus8.done), 32'((i % 10) == 8));
         chk($sformatf("hold%0d_busy", i), 32'(bus8.busy), 32'((i % 10) < 8));
         if ((i % 10) == 8) begin
            r8 = ref_sub8(av[i - 8], bv[i - 8]);
            last_d  = r8[7:0];
            last_bo = r8[8];
         end
         chk($sformatf("hold%0d_diff", i), 32'(bus8.diff), 32'(last_d));
         chk($sformatf("hold%0d_bout", i), 32'(bus8.bout), 32'(last_bo));
      end
      bus8.start = 1'b0;
      @(posedge clk); #1;

      // Reset between edges after three bits of a run.
      op8(8'h35, 8'h12, d8, bo, lat);
      chk("pre_rst_diff", 32'(d8), 32'(8'h23));
      bus8.start = 1'b1; bus8.a = 8'h9C; bus8.b = 8'hE1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (3) @(posedge clk);
      #4 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(bus8.busy), 32'(0));
      chk("async_rst_done", 32'(bus8.done), 32'(0));
      chk("async_rst_diff", 32'(bus8.diff), 32'(0));
      chk("async_rst_bout", 32'(bus8.bout), 32'(0));
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      op8(8'h9C, 8'hE1, d8, bo, lat);
      r8 = ref_sub8(8'h9C, 8'hE1);
      chk("post_rst_latency", 32'(lat), 32'(8));
      chk("post_rst_diff", 32'(d8), 32'(r8[7:0]));
      chk("post_rst_bout", 32'(bo), 32'(r8[8]));

      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            r4 = ref_sub4(4'(ia), 4'(ib));
            op4(4'(ia), 4'(ib), d4, bo, lat);
            chk($sformatf("w4_%0d_%0d_latency", ia, ib), 32'(lat), 32'(4));
            chk($sformatf("w4_%0d_%0d_diff", ia, ib), 32'(d4), 32'(r4[3:0]));
            chk($sformatf("w4_%0d_%0d_bout", ia, ib), 32'(bo), 32'(r4[4]));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
